// File: rtl/key_gfunc_serial_if.sv
// Handshake/data bundle between the AES-128 key-expansion g-function stage and its neighbours.
// The master side drives control and the previous key; the slave side returns g(w3) and the key copy.
interface key_gfunc_serial_if;
  logic         init_i;
  logic         start_i;
  logic [127:0] key_prev_i;
  logic         ready_i;
  logic [31:0]  word_o;
  logic [127:0] key_o;
  logic         valid_o;
  logic         busy_o;
  logic [3:0]   round_o;
  logic         done_o;

  modport master (
    output init_i, start_i, key_prev_i, ready_i,
    input  word_o, key_o, valid_o, busy_o, round_o, done_o
  );

  modport slave (
    input  init_i, start_i, key_prev_i, ready_i,
    output word_o, key_o, valid_o, busy_o, round_o, done_o
  );
endinterface

// File: rtl/key_gfunc_serial.sv
// AES-128 key-expansion g-function: g(w3) = SubWord(RotWord(w3)) ^ {Rcon,24'h0}, computed with
// SBOX_LANES time-multiplexed S-boxes. Owns the round counter and Rcon, and forwards the previous key.
module key_gfunc_serial #(
  parameter int SBOX_LANES = 1,
  parameter int NUM_ROUNDS = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  key_gfunc_serial_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SUB, OUT} state_t;

  localparam logic [2:0] LANES_W    = 3'(SBOX_LANES);
  localparam logic [2:0] LAST_IDX   = 3'(4 - SBOX_LANES);
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  state_t       r_state,    w_state_nx;
  logic [31:0]  r_work,     w_work_nx;
  logic [2:0]   r_byte_idx, w_byte_idx_nx;
  logic [31:0]  r_word,     w_word_nx;
  logic [127:0] r_key,      w_key_nx;
  logic [3:0]   r_round,    w_round_nx;
  logic [7:0]   r_rcon,     w_rcon_nx;
  logic         r_done,     w_done_nx;
  logic [31:0]  w_subst;
  logic [31:0]  w_sub;

  // The top SBOX_LANES bytes are substituted and the word rotated left, so after 4/SBOX_LANES
  // steps every byte has passed through an S-box and sits back in its original position.
  always_comb begin
    w_subst = r_work;
    for (int l = 0; l < SBOX_LANES; l++) begin
      w_subst[31 - 8*l -: 8] = SBOX[r_work[31 - 8*l -: 8]];
    end
    w_sub = (w_subst << (8*SBOX_LANES)) | (w_subst >> (32 - 8*SBOX_LANES));
  end

  // NOTE: every next-state signal gets a default first, so no path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nx    = r_state;
    w_work_nx     = r_work;
    w_byte_idx_nx = r_byte_idx;
    w_word_nx     = r_word;
    w_key_nx      = r_key;
    w_round_nx    = r_round;
    w_rcon_nx     = r_rcon;
    w_done_nx     = r_done;

    unique case (r_state)
      IDLE: begin
        if (bus.start_i && !r_done) begin
          w_key_nx      = bus.key_prev_i;
          w_work_nx     = {bus.key_prev_i[23:0], bus.key_prev_i[31:24]};
          w_byte_idx_nx = '0;
          w_state_nx    = SUB;
        end
      end
      SUB: begin
        w_work_nx     = w_sub;
        w_byte_idx_nx = r_byte_idx + LANES_W;
        if (r_byte_idx == LAST_IDX) begin
          w_word_nx  = w_sub ^ {r_rcon, 24'h0};
          w_state_nx = OUT;
        end
      end
      OUT: begin
        if (bus.ready_i) begin
          w_state_nx = IDLE;
          if (r_round == LAST_ROUND) begin
            w_done_nx = 1'b1;
          end else begin
            w_round_nx = r_round + 4'd1;
            w_rcon_nx  = xtime(r_rcon);
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase

    // Restart overrides everything but leaves the last published word and key visible.
    if (bus.init_i) begin
      w_state_nx = IDLE;
      w_word_nx  = r_word;
      w_key_nx   = r_key;
      w_round_nx = 4'd1;
      w_rcon_nx  = 8'h01;
      w_done_nx  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_work     <= '0;
      r_byte_idx <= '0;
      r_word     <= '0;
      r_key      <= '0;
      r_round    <= 4'd1;
      r_rcon     <= 8'h01;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_work     <= w_work_nx;
      r_byte_idx <= w_byte_idx_nx;
      r_word     <= w_word_nx;
      r_key      <= w_key_nx;
      r_round    <= w_round_nx;
      r_rcon     <= w_rcon_nx;
      r_done     <= w_done_nx;
    end
  end

  assign bus.word_o  = r_word;
  assign bus.key_o   = r_key;
  assign bus.valid_o = (r_state == OUT);
  assign bus.busy_o  = (r_state != IDLE);
  assign bus.round_o = r_round;
  assign bus.done_o  = r_done;

endmodule

// File: tb/tb_key_gfunc_serial.sv
// Directed bench for key_gfunc_serial using the FIPS-197 A.1 key schedule; three instances
// (1, 2 and 4 S-box lanes) share the same stimulus, the 1-lane one is checked throughout.
module tb_key_gfunc_serial;

  logic         clk = 1'b0;
  logic         rst;
  logic         init;
  logic         start;
  logic         ready;
  logic [127:0] key_prev;

  int n_checks = 0;
  int n_errors = 0;

  // FIPS-197 A.1 cipher key followed by round keys 1..9
  logic [127:0] keys [10] = '{
    128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
    128'ha0fafe17_88542cb1_23a33939_2a6c7605,
    128'hf2c295f2_7a96b943_5935807a_7359f67f,
    128'h3d80477d_4716fe3e_1e237e44_6d7a883b,
    128'hef44a541_a8525b7f_b671253b_db0bad00,
    128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc,
    128'h6d88a37a_110b3efd_dbf98641_ca0093fd,
    128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f,
    128'head27321_b58dbad2_312bf560_7f8d292f,
    128'hac7766f3_19fadc21_28d12941_575c006e
  };
  // g(w3) for each round, worked out by hand from the S-box table
  logic [31:0] g_words [10] = '{
    32'h8b84eb01, 32'h52386be5, 32'hcf42d28f, 32'hd2c4e23c, 32'h3b9563b9,
    32'hb9596582, 32'h23dc5474, 32'ha486842f, 32'h46a515d2, 32'h7c639f5b
  };
  // S-box of the rotated leading byte, i.e. SubWord(RotWord(w3))[31:24]
  logic [7:0] sub_hi [10] = '{
    8'h8a, 8'h50, 8'hcb, 8'hda, 8'h2b, 8'h99, 8'h63, 8'h24, 8'h5d, 8'h4a
  };
  logic [7:0] rcons [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  key_gfunc_serial_if if1 ();
  key_gfunc_serial_if if2 ();
  key_gfunc_serial_if if4 ();

  assign if1.init_i = init;  assign if1.start_i = start;
  assign if1.ready_i = ready; assign if1.key_prev_i = key_prev;
  assign if2.init_i = init;  assign if2.start_i = start;
  assign if2.ready_i = ready; assign if2.key_prev_i = key_prev;
  assign if4.init_i = init;  assign if4.start_i = start;
  assign if4.ready_i = ready; assign if4.key_prev_i = key_prev;

  key_gfunc_serial #(.SBOX_LANES(1), .NUM_ROUNDS(10)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));
  key_gfunc_serial #(.SBOX_LANES(2), .NUM_ROUNDS(10)) u_dut2 (.clk_i(clk), .rst_i(rst), .bus(if2));
  key_gfunc_serial #(.SBOX_LANES(4), .NUM_ROUNDS(10)) u_dut4 (.clk_i(clk), .rst_i(rst), .bus(if4));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_init();
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
  endtask

  // One full round with ready_i held high; r indexes the key schedule tables.
  task automatic do_round(input string tag, input int r);
    int n;
    check({tag, " round_o"}, 128'(if1.round_o), 128'(r + 1));
    key_prev = keys[r];
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n     = 1;
    while (!if1.valid_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " valid_o"}, 128'(if1.valid_o), 128'(1));
    check({tag, " latency"}, 128'(n), 128'(5));
    check({tag, " word_o"}, 128'(if1.word_o), 128'(g_words[r]));
    check({tag, " key_o"}, if1.key_o, keys[r]);
    check({tag, " rcon"}, 128'(if1.word_o[31:24] ^ sub_hi[r]), 128'(rcons[r]));
    @(posedge clk); #1;
    check({tag, " valid_o after ack"}, 128'(if1.valid_o), 128'(0));
  endtask

  initial begin
    int lat1, lat2, lat4;
    logic [31:0] wd1, wd2, wd4;

    rst = 1'b1; init = 1'b0; start = 1'b0; ready = 1'b1; key_prev = '0;
    #12;
    check("reset word_o",  128'(if1.word_o),  128'(0));
    check("reset key_o",   if1.key_o,         128'(0));
    check("reset valid_o", 128'(if1.valid_o), 128'(0));
    check("reset busy_o",  128'(if1.busy_o),  128'(0));
    check("reset done_o",  128'(if1.done_o),  128'(0));
    check("reset round_o", 128'(if1.round_o), 128'(1));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // T1 / T2
    pulse_init();
    do_round("t1", 0);
    check("t1 round advance", 128'(if1.round_o), 128'(2));
    do_round("t2", 1);

    // T3: backpressure with an ignored start during OUT
    ready    = 1'b0;
    key_prev = keys[2];
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 20 && !if1.valid_o; n++) begin
      @(posedge clk); #1;
    end
    check("t3 valid_o", 128'(if1.valid_o), 128'(1));
    check("t3 word_o",  128'(if1.word_o),  128'(g_words[2]));
    for (int i = 0; i < 7; i++) begin
      start = (i == 2);
      if (i == 2) key_prev = keys[0];
      @(posedge clk); #1;
      check("t3 hold valid_o", 128'(if1.valid_o), 128'(1));
      check("t3 hold word_o",  128'(if1.word_o),  128'(g_words[2]));
      check("t3 hold round_o", 128'(if1.round_o), 128'(3));
      check("t3 hold key_o",   if1.key_o,         keys[2]);
    end
    start = 1'b0;
    ready = 1'b1;
    @(posedge clk); #1;
    check("t3 release valid_o", 128'(if1.valid_o), 128'(0));
    check("t3 release busy_o",  128'(if1.busy_o),  128'(0));
    check("t3 release round_o", 128'(if1.round_o), 128'(4));

    // T4: remaining rounds up to done
    for (int r = 3; r < 10; r++) begin
      do_round("t4", r);
    end
    check("t4 done_o",  128'(if1.done_o),  128'(1));
    check("t4 round_o", 128'(if1.round_o), 128'(10));
    key_prev = keys[0];
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t4 start after done busy_o", 128'(if1.busy_o), 128'(0));
    @(posedge clk); #1;
    check("t4 start after done busy_o 2", 128'(if1.busy_o), 128'(0));

    // T5: init in the 2nd SUB cycle of round 3
    pulse_init();
    check("t5 init done_o",  128'(if1.done_o),  128'(0));
    do_round("t5 r1", 0);
    do_round("t5 r2", 1);
    key_prev = keys[2];
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("t5 busy in sub", 128'(if1.busy_o), 128'(1));
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    check("t5 abort busy_o",  128'(if1.busy_o),  128'(0));
    check("t5 abort round_o", 128'(if1.round_o), 128'(1));
    check("t5 abort done_o",  128'(if1.done_o),  128'(0));
    check("t5 abort word_o kept", 128'(if1.word_o), 128'(g_words[1]));
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("t5 no valid_o", 128'(if1.valid_o), 128'(0));
    end
    do_round("t5 restart", 0);

    // T6: asynchronous reset while in OUT
    ready    = 1'b0;
    key_prev = keys[1];
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 20 && !if1.valid_o; n++) begin
      @(posedge clk); #1;
    end
    check("t6 in OUT", 128'(if1.valid_o), 128'(1));
    #2;
    rst = 1'b1;
    #1;
    check("t6 word_o",  128'(if1.word_o),  128'(0));
    check("t6 key_o",   if1.key_o,         128'(0));
    check("t6 valid_o", 128'(if1.valid_o), 128'(0));
    check("t6 busy_o",  128'(if1.busy_o),  128'(0));
    check("t6 done_o",  128'(if1.done_o),  128'(0));
    check("t6 round_o", 128'(if1.round_o), 128'(1));
    @(negedge clk);
    rst = 1'b0;

    // T1 repeated on all three lane widths in parallel
    ready    = 1'b1;
    key_prev = keys[0];
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat1 = 0; lat2 = 0; lat4 = 0;
    wd1 = '0; wd2 = '0; wd4 = '0;
    for (int n = 1; n <= 8; n++) begin
      if (lat1 == 0 && if1.valid_o) begin lat1 = n; wd1 = if1.word_o; end
      if (lat2 == 0 && if2.valid_o) begin lat2 = n; wd2 = if2.word_o; end
      if (lat4 == 0 && if4.valid_o) begin lat4 = n; wd4 = if4.word_o; end
      @(posedge clk); #1;
    end
    check("lanes1 latency", 128'(lat1), 128'(5));
    check("lanes2 latency", 128'(lat2), 128'(3));
    check("lanes4 latency", 128'(lat4), 128'(2));
    check("lanes1 word_o",  128'(wd1),  128'(32'h8b84eb01));
    check("lanes2 word_o",  128'(wd2),  128'(32'h8b84eb01));
    check("lanes4 word_o",  128'(wd4),  128'(32'h8b84eb01));
    check("lanes2 key_o",   if2.key_o,  keys[0]);
    check("lanes4 round_o", 128'(if4.round_o), 128'(2));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
